// File: rtl/cam_pkg.sv
// Shared encodings for the CAM write-side controller: response status, request op, FSM state.
package cam_pkg;

  typedef enum logic [1:0] {
    CAM_ST_OK        = 2'd0,
    CAM_ST_FULL      = 2'd1,
    CAM_ST_NOT_FOUND = 2'd2,
    CAM_ST_DUPLICATE = 2'd3
  } cam_status_e;

  typedef enum logic {
    CAM_OP_INSERT = 1'b0,
    CAM_OP_DELETE = 1'b1
  } cam_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ALLOC = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } cam_state_e;

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: index of the lowest ("HIGH" LSB priority) or highest set bit, plus any-set flag.
module priority_encoder #(
  parameter int unsigned WIDTH        = 32,
  parameter string       LSB_PRIORITY = "HIGH",
  localparam int unsigned OUT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  // Later loop iterations overwrite earlier ones, so scan order sets the winner.
  always_comb begin
    out   = '0;
    valid = 1'b0;
    if (LSB_PRIORITY == "HIGH") begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (in[i]) begin
          out   = OUT_W'(i);
          valid = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (in[i]) begin
          out   = OUT_W'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cam_update_ctrl.sv
// Key-level insert/delete front end for the block-RAM CAM; owns entry allocation via a shadow table.
// Optional CAM_DUP_CHECK_EN: inserts scan for an existing copy and answer DUPLICATE without writing.
module cam_update_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [ADDR_WIDTH:0]   free_count
);

  localparam int unsigned N     = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  cam_state_e            state;
  cam_op_e               op_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [N-1:0]          valid_bm;
  logic [DATA_WIDTH-1:0] key_mem [N];

  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  free_any;
  logic                  scan_hit_c;
  logic                  alloc_ok_c;
  logic                  go_issue_c;
  logic                  fire_c;
  logic [ADDR_WIDTH-1:0] issue_addr_c;

  priority_encoder #(
    .WIDTH        (N),
    .LSB_PRIORITY ("HIGH")
  ) u_free_enc (
    .in    (~valid_bm),
    .out   (free_idx),
    .valid (free_any)
  );

  // A write can leave straight from SCAN/ALLOC when the CAM is idle; ISSUE only absorbs busy stalls.
  always_comb begin
    scan_hit_c   = valid_bm[idx_q] && (key_mem[idx_q] == key_q);
    alloc_ok_c   = free_any && (free_count != '0);
    go_issue_c   = 1'b0;
    issue_addr_c = addr_q;
    case (state)
      ST_SCAN: begin
        if (scan_hit_c && (op_q == CAM_OP_DELETE)) begin
          go_issue_c   = 1'b1;
          issue_addr_c = idx_q;
        end
      end
      ST_ALLOC: begin
        if (alloc_ok_c) begin
          go_issue_c   = 1'b1;
          issue_addr_c = free_idx;
        end
      end
      ST_ISSUE: go_issue_c = 1'b1;
      default:  go_issue_c = 1'b0;
    endcase
    fire_c = go_issue_c && !cam_write_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      op_q             <= CAM_OP_INSERT;
      key_q            <= '0;
      idx_q            <= '0;
      addr_q           <= '0;
      valid_bm         <= '0;
      free_count       <= CNT_W'(N);
      req_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_status       <= CAM_ST_OK;
      rsp_addr         <= '0;
      cam_write_addr   <= '0;
      cam_write_data   <= '0;
      cam_write_delete <= 1'b0;
      cam_write_enable <= 1'b0;
    end else begin
      cam_write_enable <= 1'b0;
      rsp_valid        <= 1'b0;
      if (fire_c) begin
        cam_write_enable <= 1'b1;
        cam_write_addr   <= issue_addr_c;
        cam_write_data   <= key_q;
        cam_write_delete <= (op_q == CAM_OP_DELETE);
        addr_q           <= issue_addr_c;
        if (op_q == CAM_OP_DELETE) begin
          valid_bm[issue_addr_c] <= 1'b0;
          free_count             <= free_count + CNT_W'(1);
        end else begin
          valid_bm[issue_addr_c] <= 1'b1;
          free_count             <= free_count - CNT_W'(1);
        end
        state <= ST_WAIT;
      end else if (go_issue_c) begin
        addr_q <= issue_addr_c;
        state  <= ST_ISSUE;
      end else begin
        case (state)
          ST_IDLE: begin
            req_ready <= 1'b1;
            if (req_valid && req_ready) begin
              req_ready <= 1'b0;
              op_q      <= cam_op_e'(req_op);
              key_q     <= req_key;
              idx_q     <= '0;
`ifdef CAM_DUP_CHECK_EN
              state     <= ST_SCAN;
`else
              state     <= req_op ? ST_SCAN : ST_ALLOC;
`endif
            end
          end
          ST_SCAN: begin
            // A hit here is always an insert: delete hits leave through the issue path.
            if (scan_hit_c) begin
              rsp_valid  <= 1'b1;
              rsp_status <= CAM_ST_DUPLICATE;
              rsp_addr   <= idx_q;
              state      <= ST_RESP;
            end else if (idx_q == ADDR_WIDTH'(N - 1)) begin
              if (op_q == CAM_OP_DELETE) begin
                rsp_valid  <= 1'b1;
                rsp_status <= CAM_ST_NOT_FOUND;
                rsp_addr   <= '0;
                state      <= ST_RESP;
              end else begin
                state <= ST_ALLOC;
              end
            end else begin
              idx_q <= idx_q + ADDR_WIDTH'(1);
            end
          end
          ST_ALLOC: begin
            rsp_valid  <= 1'b1;
            rsp_status <= CAM_ST_FULL;
            rsp_addr   <= '0;
            state      <= ST_RESP;
          end
          ST_WAIT: begin
            // The enable cycle itself is the first WAIT cycle; CAM busy is not valid until after it.
            if (!cam_write_enable && !cam_write_busy) begin
              rsp_valid  <= 1'b1;
              rsp_status <= CAM_ST_OK;
              rsp_addr   <= addr_q;
              state      <= ST_RESP;
            end
          end
          ST_RESP: begin
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Key storage is never reset; the valid bitmap alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (fire_c && (op_q == CAM_OP_INSERT)) begin
      key_mem[issue_addr_c] <= key_q;
    end
  end

endmodule
